uio_bus_arbiter: RTL and testbench

- Shares the 8-bit bidirectional uio pad bus (uio_in/uio_out/uio_oe) of a tt_um top level between NUM_REQ internal requesters.
- Round-robin grant, bounded bursts, and a mandatory undriven turnaround cycle around every burst, so two drivers never overlap on the pads.
- Sits directly behind the tt_um top-level ports.
- Owns uio_out and uio_oe exclusively; no other logic drives them.

---
 rtl/uio_bus_arbiter.sv | 111 +++++++++++
 tb/tb_uio_bus_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the tt_um uio pad bus between NUM_REQ requesters, with a turnaround cycle around every burst.
// Optional per-requester burst lock is compiled in with `define UIO_ARB_LOCK_EN.
module uio_bus_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_dir,
  input  logic [8*NUM_REQ-1:0] wdata,
`ifdef UIO_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]   lock,
`endif
  output logic [NUM_REQ-1:0]   grant,
  output logic                 ack,
  output logic [7:0]           rdata,
  output logic                 rvalid,
  input  logic [7:0]           uio_in,
  output logic [7:0]           uio_out,
  output logic [7:0]           uio_oe
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, GRANT, XFER, RELEASE} state_t;

  state_t             r_state, w_state_nxt;
  logic [PW-1:0]      r_ptr, r_owner, w_winner, w_ptr_nxt;
  logic [CW-1:0]      r_count;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_dir;
  logic               w_found, w_beat, w_locked, w_last;

  // Winner is the first requester at or above ptr, wrapping around.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = (int'(r_ptr) + i) % NUM_REQ;
      if (!w_found && req[idx]) begin
        w_found  = 1'b1;
        w_winner = PW'(idx);
      end
    end
  end

  assign w_ptr_nxt = (r_owner == PW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_beat    = (r_state == XFER) && ena && req[r_owner];

`ifdef UIO_ARB_LOCK_EN
  assign w_locked = lock[r_owner];
`else
  assign w_locked = 1'b0;
`endif

  // The count saturates so a locked burst that unlocks late still ends on its next beat.
  assign w_last = (r_count >= CW'(MAX_BURST - 1)) && !w_locked;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (ena && w_found) w_state_nxt = GRANT;
      GRANT:   w_state_nxt = (!ena || !req[r_owner]) ? RELEASE : XFER;
      XFER:    if (!w_beat || w_last) w_state_nxt = RELEASE;
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_count <= '0;
      r_grant <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (w_state_nxt == GRANT) begin
          r_owner <= w_winner;
          r_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
          r_dir   <= req_dir[w_winner];
          r_count <= '0;
        end
        XFER: if (w_beat && (r_count != CW'(MAX_BURST))) r_count <= r_count + 1'b1;
        RELEASE: begin
          r_ptr   <= w_ptr_nxt;
          r_count <= '0;
        end
        default: ;
      endcase
      if (w_state_nxt == RELEASE) r_grant <= '0;
    end
  end

  assign grant   = r_grant;
  assign ack     = w_beat;
  assign rvalid  = w_beat && !r_dir;
  assign rdata   = uio_in;
  assign uio_oe  = {8{w_beat && r_dir}};
  assign uio_out = (w_beat && r_dir) ? wdata[{r_owner, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench for uio_bus_arbiter: directed scenarios with literal expectations plus a randomized run against a burst-level model.
module tb_uio_bus_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst, ena;
  logic [N-1:0]  req, req_dir, lock;
  logic [8*N-1:0] wdata;
  logic [N-1:0]  grant;
  logic          ack, rvalid;
  logic [7:0]    rdata, uio_in, uio_out, uio_oe;

  always #5 clk = ~clk;

  uio_bus_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .req_dir(req_dir), .wdata(wdata),
`ifdef UIO_ARB_LOCK_EN
    .lock(lock),
`endif
    .grant(grant), .ack(ack), .rdata(rdata), .rvalid(rvalid),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Burst-level reference: who owns the bus, how long since the grant, beats taken, and whether
  // the bus is in its post-burst release cycle.
  int  m_owner = -1;
  int  m_age   = 0;
  int  m_beats = 0;
  int  m_ptr   = 0;
  bit  m_rel   = 0;
  bit  m_dir   = 0;
  bit  armed   = 0;
  bit  m_beat, m_lk, m_wr;
  logic [N-1:0] m_grant;

  task automatic end_burst();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_rel   = 1;
  endtask

  always @(negedge clk) begin
    if (rst) armed = 1;
    m_beat  = (m_owner >= 0) && (m_age > 0) && ena && req[m_owner];
    m_wr    = m_beat && m_dir;
    m_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    if (armed) begin
      check("mdl_grant",  grant,   m_grant);
      check("mdl_ack",    ack,     m_beat);
      check("mdl_oe",     uio_oe,  m_wr ? 8'hFF : 8'h00);
      check("mdl_out",    uio_out, m_wr ? wdata[8*m_owner +: 8] : 8'h00);
      check("mdl_rvalid", rvalid,  m_beat && !m_dir);
      check("mdl_rdata",  rdata,   uio_in);
    end
`ifdef UIO_ARB_LOCK_EN
    m_lk = (m_owner >= 0) && lock[m_owner];
`else
    m_lk = 0;
`endif
    if (rst) begin
      m_owner = -1; m_age = 0; m_beats = 0; m_ptr = 0; m_rel = 0; m_dir = 0;
    end else if (m_rel) begin
      m_rel = 0;
    end else if (m_owner < 0) begin
      if (ena && req != '0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        end
        m_dir = req_dir[m_owner]; m_age = 0; m_beats = 0;
      end
    end else if (m_age == 0) begin
      if (!ena || !req[m_owner]) end_burst();
      else m_age = 1;
    end else if (m_beat) begin
      m_beats++;
      if (m_beats >= MB && !m_lk) end_burst();
    end else begin
      end_burst();
    end
  end

  // Trace capture for directed scenarios
  logic [N-1:0] t_g  [40];
  logic         t_a  [40];
  logic         t_rv [40];
  logic [7:0]   t_oe [40];
  logic [7:0]   t_out[40];
  logic [7:0]   t_rd [40];

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      t_g[i] = grant; t_a[i] = ack; t_rv[i] = rvalid;
      t_oe[i] = uio_oe; t_out[i] = uio_out; t_rd[i] = rdata;
    end
  endtask

  // Two reset edges, then the given inputs from the first post-reset cycle (trace index 0 = IDLE).
  task automatic do_reset(input logic [N-1:0] r, input logic [N-1:0] d, input logic [31:0] wd,
                          input logic [7:0] ui, input logic [N-1:0] lk);
    rst = 1'b1; ena = 1'b1; req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; req = r; req_dir = d; wdata = wd; uio_in = ui; lock = lk;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit        xw [9]  = '{0, 0, 1, 1, 1, 1, 0, 0, 0};
  logic [3:0] gw[9]  = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h2};
`ifdef UIO_ARB_LOCK_EN
  bit        xl [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
  logic [3:0] gl[10] = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8};
`else
  bit        xl [10] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 1};
  logic [3:0] gl[10] = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h8, 4'h8};
`endif
  int starts[$];
  int acks, zeros;
  logic [3:0] rr_exp[5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};

  initial begin
    // Reset with every requester asking
    rst = 1'b1; ena = 1'b1; req = 4'b1111; req_dir = 4'b1111; wdata = 32'h11223344;
    uio_in = 8'h00; lock = '0;
    @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, 4'b0000);
    check("rst_ack", ack, 1'b0);
    check("rst_oe", uio_oe, 8'h00);
    check("rst_out", uio_out, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_idle_grant", grant, 4'b0000);
    @(negedge clk);
    check("rst_first_grant", grant, 4'b0001);

    // Write burst from requester 1
    do_reset(4'b0010, 4'b0010, 32'h7766A555, 8'h00, 4'b0000);
    capture(9);
    for (int i = 0; i < 9; i++) begin
      check("wr_grant", t_g[i], gw[i]);
      check("wr_ack", t_a[i], xw[i]);
      check("wr_oe", t_oe[i], xw[i] ? 8'hFF : 8'h00);
      check("wr_out", t_out[i], xw[i] ? 8'hA5 : 8'h00);
    end

    // Round-robin fairness with all requesters held
    do_reset(4'b1111, 4'b1010, 32'hC3B2A190, 8'h5A, 4'b0000);
    capture(36);
    starts = {};
    for (int i = 0; i < 36; i++)
      if (t_g[i] != '0 && (i == 0 || t_g[i-1] == '0)) starts.push_back(i);
    check("rr_num_bursts", starts.size(), 5);
    for (int k = 0; k < 5 && k < starts.size(); k++) check("rr_order", t_g[starts[k]], rr_exp[k]);
    for (int k = 0; k < 4 && k + 1 < starts.size(); k++) begin
      acks = 0; zeros = 0;
      for (int i = starts[k]; i < starts[k+1]; i++) begin
        if (t_a[i]) acks++;
        if (t_g[i] == '0) zeros++;
      end
      check("rr_acks_per_grant", acks, 4);
      check("rr_idle_gap", zeros, 2);
    end

    // Read burst from requester 2
    do_reset(4'b0100, 4'b1011, 32'hFFFFFFFF, 8'h3C, 4'b0000);
    capture(9);
    acks = 0;
    for (int i = 0; i < 9; i++) begin
      check("rd_oe", t_oe[i], 8'h00);
      check("rd_rvalid", t_rv[i], t_a[i]);
      if (t_a[i]) begin
        acks++;
        check("rd_rdata", t_rd[i], 8'h3C);
      end
    end
    check("rd_ack_count", acks, 4);

    // Requester drops after two beats
    do_reset(4'b0001, 4'b0001, 32'h0000005A, 8'h00, 4'b0000);
    @(negedge clk);
    @(negedge clk); check("drop_grant", grant, 4'b0001); check("drop_turnaround_ack", ack, 1'b0);
    @(negedge clk); check("drop_ack1", ack, 1'b1); check("drop_out", uio_out, 8'h5A);
    @(negedge clk); check("drop_ack2", ack, 1'b1);
    step(); req = '0;
    @(negedge clk); check("drop_exit_ack", ack, 1'b0); check("drop_exit_oe", uio_oe, 8'h00);
    @(negedge clk); check("drop_release_grant", grant, 4'b0000);

    // Enable drops mid-burst
    do_reset(4'b0001, 4'b0001, 32'h0000005A, 8'h00, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); check("ena_ack_before", ack, 1'b1);
    step(); ena = 1'b0;
    @(negedge clk); check("ena_no_ack", ack, 1'b0); check("ena_no_oe", uio_oe, 8'h00);
    @(negedge clk); check("ena_grant_off", grant, 4'b0000);
    @(negedge clk); check("ena_blocks_grant", grant, 4'b0000);
    step(); ena = 1'b1;

    // Reset mid-burst
    do_reset(4'b0010, 4'b0010, 32'h0000A500, 8'h00, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); check("mrst_out_before", uio_out, 8'hA5);
    step(); rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mrst_grant", grant, 4'b0000);
    check("mrst_ack", ack, 1'b0);
    check("mrst_oe", uio_oe, 8'h00);
    check("mrst_out", uio_out, 8'h00);
    check("mrst_rvalid", rvalid, 1'b0);

    // Lock on requester 3: unlimited burst when compiled in, MAX_BURST otherwise
    do_reset(4'b1000, 4'b1000, 32'hA5000000, 8'h00, 4'b1000);
    capture(10);
    for (int i = 0; i < 10; i++) begin
      check("lock_grant", t_g[i], gl[i]);
      check("lock_ack", t_a[i], xl[i]);
    end
    step(); req = '0; lock = '0;

    // Randomized traffic checked by the model
    do_reset(4'b0000, 4'b0000, 32'h0, 8'h00, 4'b0000);
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(5) == 0) req[b] = ~req[b];
        if ($urandom_range(7) == 0) lock[b] = ~lock[b];
      end
      req_dir = N'($urandom);
      wdata   = $urandom;
      uio_in  = 8'($urandom);
      ena     = ($urandom_range(15) != 0);
      rst     = ($urandom_range(299) == 0);
    end
    step(); rst = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
